probe_uplink_arbiter: RTL and testbench

PROBE_UPLINK_ARBITER -- requirements
Module: probe_uplink_arbiter

---
 rtl/probe_uplink_arbiter_if.sv | 25 ++
 rtl/probe_uplink_arbiter.sv | 135 +++++++++++++
 tb/tb_probe_uplink_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/probe_uplink_arbiter_if.sv
// rtl/probe_uplink_arbiter_if.sv - probe uplink and merged-output signal bundle
interface probe_uplink_arbiter_if #(
    parameter int NumProbes = 4
);
    logic [32*NumProbes-1:0] PDATA;
    logic [NumProbes-1:0]    PVALID;
    logic [NumProbes-1:0]    PDELAY;
    logic [NumProbes-1:0]    PACK;
    logic [31:0]             DATAOUT;
    logic                    OUTVALID;
    logic                    OUTREADY;
    logic                    DELAY;
    logic [15:0]             PKTCOUNT;
    logic                    ERR;

    modport master (
        output PDATA, PVALID, PDELAY, OUTREADY,
        input  PACK, DATAOUT, OUTVALID, DELAY, PKTCOUNT, ERR
    );

    modport slave (
        input  PDATA, PVALID, PDELAY, OUTREADY,
        output PACK, DATAOUT, OUTVALID, DELAY, PKTCOUNT, ERR
    );
endinterface

// File: rtl/probe_uplink_arbiter.sv
// rtl/probe_uplink_arbiter.sv - round-robin packet arbiter merging probe uplinks
module probe_uplink_arbiter #(
    parameter int NumProbes = 4
) (
    input  logic                  UCLK,
    input  logic                  URST,
    probe_uplink_arbiter_if.slave bus
);
    localparam int GW = (NumProbes > 1) ? $clog2(NumProbes) : 1;

    typedef enum logic [1:0] {IDLE, LOCKED, GAP} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rrptr_q, rrptr_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          first_q, first_d;
    logic [15:0]   pktcount_q, pktcount_d;
    logic          err_q, err_d;

    logic [31:0]   pword [NumProbes];
    logic [31:0]   dout;
    logic          gvalid;
    logic          accept;
    logic          pkt_end;
    logic [GW-1:0] pick;
    logic [GW-1:0] grant_inc;

    for (genvar i = 0; i < NumProbes; i++) begin : g_unpack
        assign pword[i] = bus.PDATA[32*i +: 32];
    end

    assign dout   = pword[grant_q];
    assign gvalid = bus.PVALID[grant_q];

    // First requester at or after rrptr, wrapping modulo NumProbes
    always_comb begin : pick_proc
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NumProbes; i++) begin
            idx = int'(rrptr_q) + i;
            if (idx >= NumProbes) idx = idx - NumProbes;
            if (!found && bus.PVALID[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin : inc_proc
        int t;
        t = int'(grant_q) + 1;
        if (t >= NumProbes) t = 0;
        grant_inc = GW'(t);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rrptr_d     = rrptr_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        pktcount_d  = pktcount_q;
        err_d       = err_q;
        accept      = (state_q == LOCKED) && gvalid && bus.OUTREADY;
        pkt_end     = 1'b0;
        bus.PACK     = '0;
        bus.OUTVALID = (state_q == LOCKED) && gvalid;
        if (accept) bus.PACK[grant_q] = 1'b1;

        case (state_q)
            IDLE: begin
                if (|bus.PVALID) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    // remaining==1 here means this word drives the count to zero
                    pkt_end = first_q ? (dout[7:0] == 8'd0) : (remaining_q == 8'd1);
                    if (first_q) begin
                        remaining_d = dout[7:0];
                        first_d     = 1'b0;
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                    end
                    if (pkt_end) begin
                        pktcount_d  = pktcount_q + 16'd1;
                        rrptr_d     = grant_inc;
                        first_d     = 1'b1;
                        remaining_d = 8'd0;
                        state_d     = GAP;
                    end
                end else if (!gvalid && !first_q) begin
                    err_d       = 1'b1;
                    rrptr_d     = grant_inc;
                    first_d     = 1'b1;
                    remaining_d = 8'd0;
                    state_d     = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge UCLK or negedge URST) begin
        if (!URST) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rrptr_q     <= '0;
            remaining_q <= 8'd0;
            first_q     <= 1'b1;
            pktcount_q  <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rrptr_q     <= rrptr_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            pktcount_q  <= pktcount_d;
            err_q       <= err_d;
        end
    end

    assign bus.DATAOUT  = dout;
    assign bus.DELAY    = |bus.PDELAY;
    assign bus.PKTCOUNT = pktcount_q;
    assign bus.ERR      = err_q;
endmodule

// File: tb/tb_probe_uplink_arbiter.sv
// tb/tb_probe_uplink_arbiter.sv - scoreboard bench for probe_uplink_arbiter
module tb_probe_uplink_arbiter;
    localparam int NP = 4;

    logic UCLK = 1'b0;
    logic URST = 1'b0;

    probe_uplink_arbiter_if #(.NumProbes(NP)) bus ();

    probe_uplink_arbiter #(.NumProbes(NP)) dut (
        .UCLK (UCLK),
        .URST (URST),
        .bus  (bus)
    );

    always #5 UCLK = ~UCLK;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] src [NP][$];
    logic [33:0] exp_q [$];
    int          acc_cyc [$];
    bit          tog_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input int p, input logic [31:0] w);
        src[p].push_back(w);
        exp_q.push_back({2'(p), w});
    endtask

    task automatic clr();
        for (int p = 0; p < NP; p++) src[p].delete();
        exp_q.delete();
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus.PVALID[p]        = (src[p].size() > 0);
            bus.PDATA[32*p +: 32] = (src[p].size() > 0) ? src[p][0] : 32'h0;
        end
        bus.PDELAY   = NP'($urandom_range(0, (1 << NP) - 1));
        bus.OUTREADY = tog_rdy ? (cycle % 2 == 0) : 1'b1;
    endtask

    task automatic monitor();
        logic [33:0] e;
        chk("delay_or", 32'(bus.DELAY), 32'(|bus.PDELAY));
        if (bus.OUTVALID && bus.OUTREADY) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pack", 32'(bus.PACK), 32'(1 << e[33:32]));
                chk("dataout", bus.DATAOUT, e[31:0]);
                acc_cyc.push_back(cycle);
            end
        end else begin
            chk("pack_idle", 32'(bus.PACK), 32'd0);
        end
    endtask

    task automatic cyc();
        logic [NP-1:0] ack;
        @(negedge UCLK);
        monitor();
        ack = bus.PACK;
        @(posedge UCLK);
        #1;
        cycle++;
        for (int p = 0; p < NP; p++)
            if (ack[p] && src[p].size() > 0) void'(src[p].pop_front());
        drive();
    endtask

    task automatic wait_pkt(input logic [15:0] n, input int budget, input string tag);
        int k = 0;
        while (bus.PKTCOUNT !== n && k < budget) begin
            cyc();
            k++;
        end
        chk(tag, 32'(bus.PKTCOUNT), 32'(n));
    endtask

    task automatic hard_reset();
        URST = 1'b0;
        clr();
        drive();
        cyc();
        cyc();
        URST = 1'b1;
    endtask

    initial begin
        int k;
        bus.PDATA    = '0;
        bus.PVALID   = '0;
        bus.PDELAY   = '0;
        bus.OUTREADY = 1'b0;
        drive();
        repeat (3) cyc();
        chk("rst_outvalid", 32'(bus.OUTVALID), 32'd0);
        chk("rst_pack", 32'(bus.PACK), 32'd0);
        chk("rst_pktcount", 32'(bus.PKTCOUNT), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);

        // single probe, header N=2
        push(1, 32'h0001_0002);
        push(1, 32'hCAFE_0001);
        push(1, 32'hCAFE_0002);
        drive();
        acc_cyc.delete();
        URST = 1'b1;
        wait_pkt(16'd1, 20, "t1_pktcount");
        chk("t1_gap_outvalid", 32'(bus.OUTVALID), 32'd0);
        chk("t1_acc_count", 32'(acc_cyc.size()), 32'd3);
        if (acc_cyc.size() == 3)
            chk("t1_consecutive", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
        cyc();
        chk("t1_idle_outvalid", 32'(bus.OUTVALID), 32'd0);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // round robin over probes 0,2,3 with N=0 packets
        URST = 1'b0;
        clr();
        push(0, 32'hA000_0000);
        push(2, 32'hA200_0000);
        push(3, 32'hA300_0000);
        push(0, 32'hB000_0000);
        drive();
        cyc();
        URST = 1'b1;
        wait_pkt(16'd4, 40, "t2_pktcount");
        cyc();
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // OUTREADY toggling during a 4-word packet
        hard_reset();
        tog_rdy = 1'b1;
        acc_cyc.delete();
        push(2, 32'h0000_0003);
        push(2, 32'hD000_0001);
        push(2, 32'hD000_0002);
        push(2, 32'hD000_0003);
        drive();
        wait_pkt(16'd1, 40, "t3_pktcount");
        tog_rdy = 1'b0;
        cyc();
        chk("t3_acc_count", 32'(acc_cyc.size()), 32'd4);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // probe 1 drops PVALID mid-packet, probe 2 waiting
        hard_reset();
        push(1, 32'h0000_0003);
        push(1, 32'h1111_1111);
        push(2, 32'h2222_0000);
        drive();
        k = 0;
        while (bus.ERR !== 1'b1 && k < 30) begin
            cyc();
            k++;
        end
        chk("t4_err", 32'(bus.ERR), 32'd1);
        chk("t4_pkt_unchanged", 32'(bus.PKTCOUNT), 32'd0);
        wait_pkt(16'd1, 20, "t4_pktcount");
        repeat (5) cyc();
        chk("t4_err_sticky", 32'(bus.ERR), 32'd1);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-packet, then probe 0 beats probe 3
        acc_cyc.delete();
        push(0, 32'h0000_0004);
        push(0, 32'hE000_0001);
        push(0, 32'hE000_0002);
        push(0, 32'hE000_0003);
        push(0, 32'hE000_0004);
        drive();
        k = 0;
        while (acc_cyc.size() < 2 && k < 30) begin
            cyc();
            k++;
        end
        chk("t5_two_sent", 32'(acc_cyc.size()), 32'd2);
        #2;
        URST = 1'b0;
        #1;
        chk("t5_async_outvalid", 32'(bus.OUTVALID), 32'd0);
        chk("t5_async_pack", 32'(bus.PACK), 32'd0);
        chk("t5_async_err", 32'(bus.ERR), 32'd0);
        chk("t5_async_pktcount", 32'(bus.PKTCOUNT), 32'd0);
        clr();
        push(0, 32'h0C00_0000);
        push(3, 32'h3C00_0000);
        drive();
        cyc();
        cyc();
        URST = 1'b1;
        wait_pkt(16'd2, 30, "t5_pktcount");
        cyc();
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
